// File: rtl/divider_pkg.sv
// divider_pkg: shared core types for the divider FSM and ALU operation codes.
package divider_pkg;
  typedef enum logic [1:0] {IDLE, INIT, WORK, FIXUP} div_state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MUL, ALU_DIV} alu_op_e;
  localparam logic [3:0] WORD_LAST = 4'd15;
  localparam logic [3:0] BYTE_LAST = 4'd7;
endpackage

// File: rtl/divider.sv
// divider: 8086-style DIV/IDIV, restoring division one quotient bit per cycle.
module divider
  import divider_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_8_bit,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        complete,
  output logic        error
);
  function automatic logic [15:0] neg16(input logic [15:0] x);
    return ~x + 16'd1;
  endfunction
  function automatic logic [15:0] abs16(input logic [15:0] x, input logic s);
    return s ? neg16(x) : x;
  endfunction
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic s);
    return s ? ~x + 32'd1 : x;
  endfunction
  div_state_e  state_q, state_d;
  logic [31:0] dd_q, dd_d;
  logic [15:0] dv_q, dv_d, dvs_q, dvs_d, acc_q, acc_d, sh_q, sh_d, quot_q, quot_d, rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        byte_q, byte_d, sgn_q, sgn_d, negq_q, negq_d, negr_q, negr_d, cmp_q, cmp_d, err_q, err_d;
  logic        sdd, sdv, init_err, ge, last, ovf;
  logic [31:0] mdd_w;
  logic [15:0] mdd_b, mdv_b, mdv_w, mdv, hi, lo, diff, qn, rn;
  logic [16:0] t;
  assign sdd = sgn_q & (byte_q ? dd_q[15] : dd_q[31]);
  assign sdv = sgn_q & (byte_q ? dv_q[7] : dv_q[15]);
  assign mdd_w = abs32(dd_q, sdd);
  assign mdd_b = abs16(dd_q[15:0], sdd);
  assign mdv_b = abs16({{8{sdv}}, dv_q[7:0]}, sdv);
  assign mdv_w = abs16(dv_q, sdv);
  assign mdv = byte_q ? mdv_b : mdv_w;
  assign hi = byte_q ? {8'h00, mdd_b[15:8]} : mdd_w[31:16];
  assign lo = byte_q ? {mdd_b[7:0], 8'h00} : mdd_w[15:0];
  // upper half >= divisor means the quotient cannot fit the destination
  assign init_err = (mdv == 16'h0000) || (hi >= mdv);
  assign t = {acc_q, sh_q[15]};
  assign ge = t >= {1'b0, dvs_q};
  assign diff = t[15:0] - dvs_q;
  assign last = cnt_q == (byte_q ? BYTE_LAST : WORD_LAST);
  assign ovf = sgn_q & (byte_q ? sh_q > 16'h007F : sh_q > 16'h7FFF);
  assign qn = negq_q ? neg16(sh_q) : sh_q;
  assign rn = negr_q ? neg16(acc_q) : acc_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dd_q    <= '0;
      dv_q    <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      byte_q  <= 1'b0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      cmp_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dd_q    <= dd_d;
      dv_q    <= dv_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? INIT : IDLE;
      INIT:    state_d = init_err ? IDLE : WORK;
      WORK:    state_d = last ? FIXUP : WORK;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    dd_d   = dd_q;
    dv_d   = dv_q;
    byte_d = byte_q;
    sgn_d  = sgn_q;
    dvs_d  = dvs_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    negq_d = negq_q;
    negr_d = negr_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    cmp_d  = 1'b0;
    err_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        dd_d   = dividend;
        dv_d   = divisor;
        byte_d = is_8_bit;
        sgn_d  = is_signed;
      end
      INIT: begin
        dvs_d  = mdv;
        acc_d  = hi;
        sh_d   = lo;
        cnt_d  = '0;
        negq_d = sdd ^ sdv;
        negr_d = sdd;
        cmp_d  = init_err;
        err_d  = init_err;
      end
      WORK: begin
        acc_d = ge ? diff : t[15:0];
        sh_d  = {sh_q[14:0], ge};
        cnt_d = cnt_q + 4'd1;
      end
      default: begin
        cmp_d = 1'b1;
        err_d = ovf;
        if (!ovf) begin
          quot_d = byte_q ? {8'h00, qn[7:0]} : qn;
          rem_d  = byte_q ? {8'h00, rn[7:0]} : rn;
        end
      end
    endcase
  end
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign busy      = state_q != IDLE;
  assign complete  = cmp_q;
  assign error     = err_q;
endmodule

// File: tb/tb_divider.sv
// tb_divider: table vectors, corner sequences and random ops against an arithmetic model.
module tb_divider;
  logic        clk = 1'b0;
  logic        reset, start, is_8_bit, is_signed;
  logic [31:0] dividend;
  logic [15:0] divisor, quotient, remainder;
  logic        busy, complete, error;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] held_q = 16'h0000;
  logic [15:0] held_r = 16'h0000;

  divider dut (
    .clk(clk), .reset(reset), .start(start), .is_8_bit(is_8_bit), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .quotient(quotient), .remainder(remainder),
    .busy(busy), .complete(complete), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bm;
    logic        sg;
    logic [31:0] dd;
    logic [15:0] dv;
    logic [15:0] q;
    logic [15:0] r;
    logic        e;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division with the 8086 range rules.
  task automatic model(input logic bm, input logic sg, input logic [31:0] dd, input logic [15:0] dv,
                       output int lat, output logic [15:0] q, output logic [15:0] r, output logic e);
    longint n, d, qq, rr, qm;
    int w;
    w = bm ? 8 : 16;
    n = bm ? (sg ? longint'($signed(dd[15:0])) : longint'(dd[15:0])) : (sg ? longint'($signed(dd)) : longint'(dd));
    d = bm ? (sg ? longint'($signed(dv[7:0])) : longint'(dv[7:0])) : (sg ? longint'($signed(dv)) : longint'(dv));
    q = held_q;
    r = held_r;
    e = 1'b1;
    lat = 2;
    if (d == 0) return;
    qm = (n < 0 ? -n : n) / (d < 0 ? -d : d);
    if (qm >= (64'sd1 << w)) return;
    lat = w + 3;
    if (sg && qm > (64'sd1 << (w - 1)) - 1) return;
    qq = n / d;
    rr = n - qq * d;
    e = 1'b0;
    q = bm ? {8'h00, 8'(qq)} : 16'(qq);
    r = bm ? {8'h00, 8'(rr)} : 16'(rr);
  endtask

  task automatic do_op(input logic bm, input logic sg, input logic [31:0] dd, input logic [15:0] dv,
                       input bit b2b, input bit intr, output int lat, output logic [15:0] q,
                       output logic [15:0] r, output logic e, output bit bok);
    int c;
    if (!b2b) @(negedge clk);
    is_8_bit = bm; is_signed = sg; dividend = dd; divisor = dv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = 16'($urandom); is_8_bit = ~bm; is_signed = ~sg;
    c = 1;
    bok = 1'b1;
    while (!complete && c < 40) begin
      if (!busy) bok = 1'b0;
      if (intr && c == 3) begin start = 1'b1; divisor = 16'h0000; end
      else start = 1'b0;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    if (busy) bok = 1'b0;
    lat = c; q = quotient; r = remainder; e = error;
  endtask

  task automatic check_op(input string nm, input logic bm, input logic sg, input logic [31:0] dd,
                          input logic [15:0] dv, input bit b2b, input bit intr, input int xlat,
                          input logic [15:0] xq, input logic [15:0] xr, input logic xe);
    int lat;
    logic [15:0] q, r;
    logic e;
    bit bok;
    do_op(bm, sg, dd, dv, b2b, intr, lat, q, r, e, bok);
    if (!xe) begin held_q = xq; held_r = xr; end
    chk({nm, " latency"}, 32'(lat), 32'(xlat));
    chk({nm, " error"}, {31'd0, e}, {31'd0, xe});
    chk({nm, " quotient"}, {16'd0, q}, {16'd0, held_q});
    chk({nm, " remainder"}, {16'd0, r}, {16'd0, held_r});
    chk({nm, " busy"}, {31'd0, bok}, 32'd1);
  endtask

  initial begin
    vec_t tbl [12];
    int xlat, c, ncmp;
    logic [15:0] xq, xr;
    logic xe, bm, sg;
    logic [31:0] dd;
    logic [15:0] dv;
    tbl[0]  = '{1'b0, 1'b0, 32'h0001_0000, 16'h0003, 16'h5555, 16'h0001, 1'b0, 19};
    tbl[1]  = '{1'b1, 1'b1, 32'h0000_FF9C, 16'h0007, 16'h00F2, 16'h00FE, 1'b0, 11};
    tbl[2]  = '{1'b0, 1'b0, 32'h1234_5678, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2};
    tbl[3]  = '{1'b0, 1'b0, 32'h0005_0000, 16'h0005, 16'h0000, 16'h0000, 1'b1, 2};
    tbl[4]  = '{1'b0, 1'b1, 32'hFFFF_0000, 16'h0002, 16'h0000, 16'h0000, 1'b1, 19};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_00FF, 16'h0010, 16'h000F, 16'h000F, 1'b0, 11};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0080, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 11};
    tbl[7]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 19};
    tbl[8]  = '{1'b1, 1'b1, 32'h0000_FF80, 16'h0001, 16'h0000, 16'h0000, 1'b1, 11};
    tbl[9]  = '{1'b0, 1'b0, 32'hFFFE_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 19};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0100, 16'h0001, 16'h0000, 16'h0000, 1'b1, 2};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0064, 16'h8000, 16'h0000, 16'h0064, 1'b0, 19};
    reset = 1'b1; start = 1'b0; is_8_bit = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset quotient", {16'd0, quotient}, 32'd0);
    chk("reset remainder", {16'd0, remainder}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset complete", {31'd0, complete}, 32'd0);
    chk("reset error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    foreach (tbl[i])
      check_op($sformatf("vec%0d", i), tbl[i].bm, tbl[i].sg, tbl[i].dd, tbl[i].dv, 1'b0, 1'b0,
               tbl[i].lat, tbl[i].q, tbl[i].r, tbl[i].e);
    // start pulsed mid-operation with a zero divisor must be ignored
    check_op("ignored start", 1'b0, 1'b0, 32'd1000, 16'd7, 1'b0, 1'b1, 19, 16'h008E, 16'h0006, 1'b0);
    // reset (with start held) in cycle 5 of a word divide
    @(negedge clk);
    is_8_bit = 1'b0; is_signed = 1'b0; dividend = 32'h0001_0000; divisor = 16'h0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (c < 5) begin @(negedge clk); c++; end
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort complete", {31'd0, complete}, 32'd0);
    chk("abort quotient", {16'd0, quotient}, 32'd0);
    reset = 1'b0; start = 1'b0;
    held_q = 16'h0000; held_r = 16'h0000;
    ncmp = 0;
    repeat (30) begin @(negedge clk); if (complete) ncmp++; end
    chk("abort no complete", 32'(ncmp), 32'd0);
    model(1'b0, 1'b0, 32'h0001_0000, 16'h0003, xlat, xq, xr, xe);
    check_op("b2b first", 1'b0, 1'b0, 32'h0001_0000, 16'h0003, 1'b0, 1'b0, xlat, xq, xr, xe);
    model(1'b1, 1'b1, 32'h0000_FF9C, 16'h0007, xlat, xq, xr, xe);
    check_op("b2b second", 1'b1, 1'b1, 32'h0000_FF9C, 16'h0007, 1'b1, 1'b0, xlat, xq, xr, xe);
    for (int k = 0; k < 150; k++) begin
      bm = 1'($urandom);
      sg = 1'($urandom);
      dd = $urandom;
      dv = 16'($urandom);
      if ($urandom_range(0, 1) == 1) dd = dd >> $urandom_range(8, 31);
      if ($urandom_range(0, 7) == 0) dv = 16'h0000;
      model(bm, sg, dd, dv, xlat, xq, xr, xe);
      check_op($sformatf("rand%0d", k), bm, sg, dd, dv, bit'($urandom_range(0, 1)), 1'b0, xlat, xq, xr, xe);
    end
    ncmp = 0;
    repeat (25) begin @(negedge clk); if (complete) ncmp++; end
    chk("idle no complete", 32'(ncmp), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter none; width fixed at 16-bit core datapath (8-bit mode via is_8_bit).
REQ-002 clk  input  1  core clock; single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled on rising clk.
REQ-005 is_8_bit  input  1  1 = byte divide (AX / r8), 0 = word divide (DX:AX / r16).
REQ-006 is_signed  input  1  1 = IDIV semantics, 0 = DIV semantics.
REQ-007 dividend  input  32  byte mode uses [15:0] only; word mode uses [31:0].
REQ-008 divisor  input  16  byte mode uses [7:0] only.
REQ-009 quotient  output  16  result; byte mode upper byte = 0.
REQ-010 remainder  output  16  result; byte mode upper byte = 0.
REQ-011 busy  output  1  high from cycle after start accepted until complete.
REQ-012 complete  output  1  single-cycle pulse: result or error ready.
REQ-013 error  output  1  divide error (INT 0 request); valid only while complete high.

Function
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored, operands not re-sampled.
REQ-015 SHALL latch is_8_bit, is_signed, dividend, divisor on the accepting edge; later input changes have no effect.
REQ-016 States: IDLE, INIT, WORK, FIXUP; transitions IDLE->INIT on start, INIT->WORK (or IDLE on error), WORK->FIXUP after N iterations, FIXUP->IDLE.
REQ-017 N = 8 in byte mode, 16 in word mode; restoring division, one quotient bit per WORK cycle.
REQ-018 INIT SHALL form magnitudes of dividend and divisor (two's complement negate when is_signed and sign bit set).
REQ-019 INIT SHALL flag error if divisor magnitude = 0, or upper-half dividend magnitude >= divisor magnitude (quotient overflow).
REQ-020 FIXUP SHALL negate quotient if dividend sign != divisor sign, negate remainder if dividend negative (signed only).
REQ-021 FIXUP SHALL flag error when signed quotient magnitude > 0x7FFF (word) or > 0x7F (byte); -32768/-128 quotients are errors (8086 behaviour).
REQ-022 Timing, start sampled in cycle 0: no error -> complete in cycle N+3 (word 19, byte 11); INIT error -> complete+error in cycle 2.
REQ-023 quotient/remainder SHALL update only with complete and hold until next completion; on error they SHALL be left unchanged.
REQ-024 busy SHALL be high in cycles 1 through the cycle before complete, low when complete is high.
REQ-025 start high in the cycle complete is high SHALL be accepted (back-to-back operation).

Reset
REQ-026 reset SHALL force IDLE; busy, complete, error = 0; quotient, remainder = 0x0000.
REQ-027 reset mid-operation SHALL abort without any complete pulse; reset has priority over start.

Structure
REQ-028 State enumeration type SHALL live in the shared core package alongside the ALU op types.
REQ-029 Single module, no sub-modules; negate/abs as local functions.

Verification
REQ-030 Unsigned word: dividend 0x0001_0000, divisor 0x0003 -> quotient 0x5555, remainder 0x0001, error 0, complete in cycle 19.
REQ-031 Signed byte: dividend 0xFF9C (-100), divisor 0x0007 -> quotient 0x00F2, remainder 0x00FE, complete in cycle 11.
REQ-032 Divide by zero: any dividend, divisor 0x0000 -> complete+error in cycle 2, outputs unchanged.
REQ-033 Unsigned overflow: dividend 0x0005_0000, divisor 0x0005 -> complete+error in cycle 2.
REQ-034 Signed boundary: dividend 0xFFFF_0000, divisor 0x0002 -> complete+error in cycle 19.
REQ-035 Reset in cycle 5 of a word divide -> busy 0 next cycle, no complete pulse; start in same cycle as complete runs a second divide.
